// File: rtl/code_decoder_if.sv
// Channel-select bus between the encoded-select source and the code_decoder.
// master drives the code and its qualifier, and slave returns the decoded select and status.
`default_nettype none

interface code_decoder_if;
  logic       code_valid;
  logic [1:0] code;
  logic [2:0] sel;
  logic [1:0] sel_code;
  logic       sel_strobe;
  logic       busy;

  modport master (
    output code_valid, code,
    input  sel, sel_code, sel_strobe, busy
  );

  modport slave (
    input  code_valid, code,
    output sel, sel_code, sel_strobe, busy
  );
endinterface

`default_nettype wire

// File: rtl/code_decoder.sv
// ==========================================================================
// code_decoder: debounces a 2-bit select code and expands it to a one-hot select.
// It then enforces a lockout after each commit. Optional macro CODE_DECODER_HOLD_EN.
// Rev 1.0
// ==========================================================================
`default_nettype none

module code_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  code_decoder_if.slave  bus
);

  localparam int C_MAX = (STABLE_CYCLES > LOCKOUT_CYCLES) ? STABLE_CYCLES : LOCKOUT_CYCLES;
  localparam int CW    = (C_MAX < 1) ? 1 : $clog2(C_MAX + 1);

  localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_LOCK_LAST   = CW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] C_ONE         = CW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

`ifdef CODE_DECODER_HOLD_EN
  localparam bit C_HOLD_ZERO = 1'b1;
`else
  localparam bit C_HOLD_ZERO = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [1:0]    sel_code_q, sel_code_d;
  logic          strobe_q, strobe_d;
  logic          busy_q;

  logic          w_take;
  logic          w_commit;
  logic [1:0]    w_commit_code;

  function automatic logic [2:0] onehot(input logic [1:0] c);
    case (c)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // In hold mode a zero code is never a usable sample.
  assign w_take = bus.code_valid && !(C_HOLD_ZERO && (bus.code == 2'd0));

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    sel_code_d    = sel_code_q;
    strobe_d      = 1'b0;
    w_commit      = 1'b0;
    w_commit_code = cand_q;

    case (state_q)
      IDLE: begin
        if (w_take && (bus.code != sel_code_q)) begin
          cand_d = bus.code;
          cnt_d  = C_ONE;
          if (STABLE_CYCLES == 1) begin
            w_commit      = 1'b1;
            w_commit_code = bus.code;
          end else begin
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (w_take && (bus.code == cand_q)) begin
          if (cnt_q == C_STABLE_LAST) begin
            w_commit = 1'b1;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else if (w_take && (bus.code != sel_code_q)) begin
          cand_d = bus.code;
          cnt_d  = C_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LOCKOUT: begin
        if (cnt_q == C_LOCK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (w_commit) begin
      sel_d      = onehot(w_commit_code);
      sel_code_d = w_commit_code;
      strobe_d   = 1'b1;
      cnt_d      = '0;
      state_d    = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= 2'd0;
      cnt_q      <= '0;
      sel_q      <= 3'b000;
      sel_code_q <= 2'd0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      sel_code_q <= sel_code_d;
      strobe_q   <= strobe_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_code   = sel_code_q;
  assign bus.sel_strobe = strobe_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_code_decoder.sv
// Directed testbench for code_decoder (STABLE_CYCLES=4, LOCKOUT_CYCLES=8).
`default_nettype none

module tb_code_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  code_decoder_if bus ();

  code_decoder #(.STABLE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] sel, input logic [1:0] code,
                            input logic strobe, input logic busy);
    check({tag, ".sel"},      {1'b0, bus.sel},      {1'b0, sel});
    check({tag, ".sel_code"}, {2'b0, bus.sel_code}, {2'b0, code});
    check({tag, ".strobe"},   {3'b0, bus.sel_strobe}, {3'b0, strobe});
    check({tag, ".busy"},     {3'b0, bus.busy},     {3'b0, busy});
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.code       = 2'd0;

    // 1. reset and idle
    #12 rst_n = 1'b1;
    #1 expect_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out($sformatf("idle%0d", i), 3'b000, 2'd0, 1'b0, 1'b0);
    end

    // 2. code=2 qualifies over 4 edges, then 8-edge lockout
    bus.code = 2'd2; bus.code_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("q2_e%0d", i), 3'b000, 2'd0, 1'b0, 1'b1);
    end
    tick();
    expect_out("q2_commit", 3'b010, 2'd2, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      expect_out($sformatf("lock2_e%0d", i), 3'b010, 2'd2, 1'b0, 1'b1);
    end
    tick();
    expect_out("lock2_end", 3'b010, 2'd2, 1'b0, 1'b0);

    // 3. code=3 for 2 edges then back to 2 aborts
    bus.code = 2'd3;
    tick(); expect_out("ab_e1", 3'b010, 2'd2, 1'b0, 1'b1);
    tick(); expect_out("ab_e2", 3'b010, 2'd2, 1'b0, 1'b1);
    bus.code = 2'd2;
    tick(); expect_out("ab_e3", 3'b010, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("ab_hold%0d", i), 3'b010, 2'd2, 1'b0, 1'b0);
    end

    // 4. commit 3, then code=1 during lockout is ignored until IDLE
    bus.code = 2'd3;
    repeat (3) tick();
    tick(); expect_out("q3_commit", 3'b100, 2'd3, 1'b1, 1'b1);
    bus.code = 2'd1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      expect_out($sformatf("lock3_e%0d", i), 3'b100, 2'd3, 1'b0, 1'b1);
    end
    tick(); expect_out("lock3_end", 3'b100, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("q1_e%0d", i), 3'b100, 2'd3, 1'b0, 1'b1);
    end
    tick(); expect_out("q1_commit", 3'b001, 2'd1, 1'b1, 1'b1);
    repeat (7) tick();
    tick(); expect_out("lock1_end", 3'b001, 2'd1, 1'b0, 1'b0);

    // 5. return to sel=010, then hold code=0
    bus.code = 2'd2;
    repeat (3) tick();
    tick(); expect_out("r2_commit", 3'b010, 2'd2, 1'b1, 1'b1);
    repeat (8) tick();
    expect_out("r2_idle", 3'b010, 2'd2, 1'b0, 1'b0);
    bus.code = 2'd0;
`ifdef CODE_DECODER_HOLD_EN
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_out($sformatf("z_hold%0d", i), 3'b010, 2'd2, 1'b0, 1'b0);
    end
`else
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("z_e%0d", i), 3'b010, 2'd2, 1'b0, 1'b1);
    end
    tick(); expect_out("z_commit", 3'b000, 2'd0, 1'b1, 1'b1);
    repeat (8) tick();
    expect_out("z_idle", 3'b000, 2'd0, 1'b0, 1'b0);
`endif

    // 6. async reset mid-QUALIFY, then a fresh qualification
    bus.code = 2'd3;
    tick(); tick();
    check("pre_rst.busy", {3'b0, bus.busy}, 4'h1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 3'b000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 expect_out("rst_rel", 3'b000, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("post_rst_e%0d", i), 3'b000, 2'd0, 1'b0, 1'b1);
    end
    tick(); expect_out("post_rst_commit", 3'b100, 2'd3, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
